// File: rtl/min_sec_countdown.sv
// MM.SS countdown timer with BCD digits, load/go/stop control and a
// one-second prescaler that holds its partial count across a pause.
//
// state | meaning
// IDLE  | preset loaded (or reset), waiting for go
// RUN   | counting down, prescaler advancing
// PAUSE | stopped mid-count, prescaler held
// DONE  | reached 00.00, waits for load or reset
module min_sec_countdown #(
    parameter int DIVISOR = 50000000
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic       load,
    input  logic       go,
    input  logic       stop,
    input  logic [3:0] d3_in,
    input  logic [3:0] d2_in,
    input  logic [3:0] d1_in,
    input  logic [3:0] d0_in,
    output logic [3:0] d3,
    output logic [3:0] d2,
    output logic [3:0] d1,
    output logic [3:0] d0,
    output logic       running,
    output logic       done,
    output logic       expired
);

    localparam int PW = $clog2(DIVISOR);
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIVISOR - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    d3_d, d2_d, d1_d, d0_d;
    logic [3:0]    dec3, dec2, dec1, dec0;
    logic [3:0]    ld3, ld2, ld1, ld0;
    logic          done_d;
    logic          is_zero;
    logic          dec_zero;
    logic          tick;

    // Out-of-range preset digits saturate to the largest legal digit.
    assign ld3 = (d3_in > 4'd9) ? 4'd9 : d3_in;
    assign ld2 = (d2_in > 4'd9) ? 4'd9 : d2_in;
    assign ld1 = (d1_in > 4'd5) ? 4'd5 : d1_in;
    assign ld0 = (d0_in > 4'd9) ? 4'd9 : d0_in;

    assign is_zero  = (d3 == 4'd0) && (d2 == 4'd0) && (d1 == 4'd0) && (d0 == 4'd0);
    assign dec_zero = (dec3 == 4'd0) && (dec2 == 4'd0) && (dec1 == 4'd0) && (dec0 == 4'd0);
    assign tick     = (state_q == RUN) && (presc_q == PRESC_LAST);

    // One-second decrement with BCD borrow chain; only used when value is nonzero.
    always_comb begin
        dec3 = d3;
        dec2 = d2;
        dec1 = d1;
        dec0 = d0 - 4'd1;
        if (d0 == 4'd0) begin
            dec0 = 4'd9;
            dec1 = d1 - 4'd1;
            if (d1 == 4'd0) begin
                dec1 = 4'd5;
                dec2 = d2 - 4'd1;
                if (d2 == 4'd0) begin
                    dec2 = 4'd9;
                    dec3 = d3 - 4'd1;
                end
            end
        end
    end

    // Next-state, prescaler and value update; priority load > stop > go.
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        d3_d    = d3;
        d2_d    = d2;
        d1_d    = d1;
        d0_d    = d0;
        done_d  = 1'b0;
        if (load) begin
            state_d = IDLE;
            presc_d = '0;
            d3_d    = ld3;
            d2_d    = ld2;
            d1_d    = ld1;
            d0_d    = ld0;
        end else begin
            case (state_q)
                IDLE, PAUSE: begin
                    if (!stop && go && !is_zero) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
                    if (tick) begin
                        d3_d = dec3;
                        d2_d = dec2;
                        d1_d = dec1;
                        d0_d = dec0;
                        // Reaching zero beats a simultaneous stop.
                        if (dec_zero) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else if (stop) begin
                            state_d = PAUSE;
                        end
                    end else if (stop) begin
                        state_d = PAUSE;
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State, prescaler, digits and registered status outputs.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= IDLE;
            presc_q <= '0;
            d3      <= 4'd0;
            d2      <= 4'd0;
            d1      <= 4'd0;
            d0      <= 4'd0;
            running <= 1'b0;
            done    <= 1'b0;
            expired <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            d3      <= d3_d;
            d2      <= d2_d;
            d1      <= d1_d;
            d0      <= d0_d;
            running <= (state_d == RUN);
            done    <= done_d;
            expired <= (state_d == DONE);
        end
    end

endmodule

// File: tb/tb_min_sec_countdown.sv
// Self-checking bench for min_sec_countdown: directed scenarios plus random
// control traffic, compared every cycle against a seconds-based model.
module tb_min_sec_countdown;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       clr_n = 1'b0;
    logic       load = 1'b0;
    logic       go = 1'b0;
    logic       stop = 1'b0;
    logic [3:0] d3_in = 4'd0, d2_in = 4'd0, d1_in = 4'd0, d0_in = 4'd0;
    logic [3:0] d3, d2, d1, d0;
    logic       running, done, expired;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: remaining time in whole seconds plus cycles into the current second.
    int m_secs = 0;
    int m_sub = 0;
    bit m_counting = 0;
    bit m_finished = 0;
    bit m_pulse = 0;

    min_sec_countdown #(.DIVISOR(DIV)) dut (
        .clk     (clk),
        .clr_n   (clr_n),
        .load    (load),
        .go      (go),
        .stop    (stop),
        .d3_in   (d3_in),
        .d2_in   (d2_in),
        .d1_in   (d1_in),
        .d0_in   (d0_in),
        .d3      (d3),
        .d2      (d2),
        .d1      (d1),
        .d0      (d0),
        .running (running),
        .done    (done),
        .expired (expired)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    function automatic logic [15:0] to_bcd(input int secs);
        int mm, ss;
        mm = secs / 60;
        ss = secs % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    function automatic int clamp(input logic [3:0] v, input int lim);
        return (int'(v) > lim) ? lim : int'(v);
    endfunction

    task automatic model_reset();
        m_secs = 0; m_sub = 0; m_counting = 0; m_finished = 0; m_pulse = 0;
    endtask

    task automatic model_step();
        m_pulse = 0;
        if (load) begin
            m_secs = (clamp(d3_in, 9) * 10 + clamp(d2_in, 9)) * 60
                   + clamp(d1_in, 5) * 10 + clamp(d0_in, 9);
            m_sub = 0; m_counting = 0; m_finished = 0;
        end else if (m_counting) begin
            if (m_sub == DIV - 1) begin
                m_sub = 0;
                m_secs = m_secs - 1;
                if (m_secs == 0) begin
                    m_counting = 0; m_finished = 1; m_pulse = 1;
                end else if (stop) begin
                    m_counting = 0;
                end
            end else begin
                m_sub = m_sub + 1;
                if (stop) m_counting = 0;
            end
        end else if (!m_finished && !stop && go && m_secs != 0) begin
            m_counting = 1;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check("value", {16'd0, d3, d2, d1, d0}, {16'd0, to_bcd(m_secs)});
        check("running", 32'(running), 32'(m_counting));
        check("done", 32'(done), 32'(m_pulse));
        check("expired", 32'(expired), 32'(m_finished));
    endtask

    task automatic set_in(input logic l, input logic g, input logic s,
                          input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] c, input logic [3:0] d);
        load = l; go = g; stop = s;
        d3_in = a; d2_in = b; d1_in = c; d0_in = d;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        // Reset state.
        #2;
        check("rst_value", {16'd0, d3, d2, d1, d0}, 32'h0);
        check("rst_flags", {29'd0, running, done, expired}, 32'h0);
        #5 clr_n = 1'b1;
        model_reset();
        cycles(2);

        // Countdown from 00.03 to completion.
        set_in(1, 0, 0, 0, 0, 0, 3); cycle();
        set_in(0, 1, 0, 0, 0, 0, 0); cycle();
        check("go_latency", 32'(running), 32'd1);
        go = 0;
        cycles(4);
        check("after_1s", {16'd0, d3, d2, d1, d0}, 32'h0002);
        cycles(8);
        check("at_zero", {16'd0, d3, d2, d1, d0}, 32'h0000);
        check("done_pulse", {29'd0, running, done, expired}, 32'b011);
        cycle();
        check("done_once", {29'd0, running, done, expired}, 32'b001);
        go = 1; cycles(2); go = 0;

        // Borrow chains.
        set_in(1, 0, 0, 0, 1, 0, 0); cycle();
        set_in(0, 1, 0, 0, 0, 0, 0); cycle(); go = 0;
        cycles(4);
        check("borrow_min", {16'd0, d3, d2, d1, d0}, 32'h0059);
        set_in(1, 0, 0, 1, 0, 0, 0); cycle();
        set_in(0, 1, 0, 0, 0, 0, 0); cycle(); go = 0;
        cycles(4);
        check("borrow_tens", {16'd0, d3, d2, d1, d0}, 32'h0959);

        // Pause mid-second and resume.
        set_in(1, 0, 0, 0, 0, 0, 5); cycle();
        set_in(0, 1, 0, 0, 0, 0, 0); cycle(); go = 0;
        cycles(5);
        stop = 1; cycle(); stop = 0;
        cycles(6);
        check("paused_hold", {16'd0, d3, d2, d1, d0}, 32'h0004);
        go = 1; cycle(); go = 0;
        cycles(6);

        // Clamping and zero preset.
        set_in(1, 0, 0, 0, 0, 7, 12); cycle();
        check("clamp", {16'd0, d3, d2, d1, d0}, 32'h0059);
        set_in(1, 0, 0, 15, 11, 6, 10); cycle();
        check("clamp_max", {16'd0, d3, d2, d1, d0}, 32'h9959);
        set_in(1, 0, 0, 0, 0, 0, 0); cycle();
        set_in(0, 1, 0, 0, 0, 0, 0); cycles(3); go = 0;
        check("zero_go", {29'd0, running, done, expired}, 32'b000);

        // Stop coinciding with the final tick.
        set_in(1, 0, 0, 0, 0, 0, 1); cycle();
        set_in(0, 1, 0, 0, 0, 0, 0); cycle(); go = 0;
        cycles(3);
        stop = 1; cycle(); stop = 0;
        check("stop_tick_done", {29'd0, running, done, expired}, 32'b011);
        cycle();

        // Load coinciding with a tick.
        set_in(1, 0, 0, 0, 0, 0, 2); cycle();
        set_in(0, 1, 0, 0, 0, 0, 0); cycle(); go = 0;
        cycles(3);
        set_in(1, 0, 0, 0, 0, 0, 1); cycle();
        load = 0;
        check("load_vs_tick", {16'd0, d3, d2, d1, d0, 13'd0, running, done, expired}, {16'h0001, 16'h0});

        // Asynchronous reset mid-run.
        set_in(1, 0, 0, 0, 0, 2, 0); cycle();
        set_in(0, 1, 0, 0, 0, 0, 0); cycle(); go = 0;
        cycles(6);
        #2 clr_n = 1'b0;
        #1;
        check("async_rst", {16'd0, d3, d2, d1, d0, 13'd0, running, done, expired}, 32'h0);
        model_reset();
        #2 clr_n = 1'b1;
        cycles(3);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            load = ($urandom_range(0, 19) == 0);
            stop = ($urandom_range(0, 9) == 0);
            go   = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 0) begin
                d3_in = 4'd0; d2_in = 4'd0; d1_in = 4'd0;
                d0_in = 4'($urandom_range(0, 3));
            end else begin
                d3_in = 4'($urandom_range(0, 15)); d2_in = 4'($urandom_range(0, 15));
                d1_in = 4'($urandom_range(0, 15)); d0_in = 4'($urandom_range(0, 15));
            end
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/min_sec_countdown.md
MIN_SEC_COUNTDOWN -- requirements
Module: min_sec_countdown

Interface
REQ-001 SHALL have parameter DIVISOR, default 50000000, clk cycles per 1 s tick (minimum 2).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port clr_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port load  input  1  synchronous load of preset value from d3_in..d0_in.
REQ-005 SHALL have port go  input  1  start or resume countdown.
REQ-006 SHALL have port stop  input  1  pause countdown.
REQ-007 SHALL have ports d3_in, d2_in, d1_in, d0_in  input  4 each  preset BCD digits: min tens, min ones, sec tens, sec ones.
REQ-008 SHALL have ports d3, d2, d1, d0  output  4 each  current remaining time as BCD, MM.SS.
REQ-009 SHALL have port running  output  1  high while in state RUN.
REQ-010 SHALL have port done  output  1  one-cycle pulse on reaching 00.00.
REQ-011 SHALL have port expired  output  1  level, high while in state DONE.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, PAUSE, DONE.
REQ-013 SHALL apply input priority load > stop > go every cycle.
REQ-014 SHALL, on load in any state: capture the preset, clear the prescaler and enter IDLE on the next edge.
REQ-015 SHALL clamp a loaded digit that is out of range: d3/d2/d0 >9 becomes 9; d1 >5 becomes 5.
REQ-016 SHALL transition IDLE→RUN and PAUSE→RUN on go only if the value is not 00.00; otherwise SHALL remain in the current state.
REQ-017 SHALL transition RUN→PAUSE on stop; go SHALL be ignored in DONE.
REQ-018 SHALL, in RUN only, increment the prescaler 0..DIVISOR-1 and wrap it to 0.
REQ-019 SHALL assert the internal tick in the RUN cycle where the prescaler equals DIVISOR-1.
REQ-020 SHALL hold the prescaler in PAUSE, so that resume continues the partial second.
REQ-021 SHALL hold the prescaler in IDLE and DONE, where it is already 0 after load or reset.
REQ-022 SHALL decrement the value by one second on each tick, with borrow chain: d0 0→9 borrows from d1; d1 0→5 borrows from d2; d2 0→9 borrows from d3.
REQ-023 SHALL never decrement the value below 00.00.
REQ-024 SHALL, on a tick that makes the value 00.00, enter DONE on that same edge and assert done for exactly that following cycle.
REQ-025 SHALL register done and expired, with no combinational path from inputs.
REQ-026 SHALL, when stop coincides with a tick, apply the decrement and then pause; if that tick reaches 00.00, DONE SHALL win over PAUSE.
REQ-027 SHALL, when load coincides with a tick, take the load and suppress the decrement and done.
REQ-028 SHALL have a maximum value of 99.59 and latency go→running of 1 cycle.

Reset
REQ-029 SHALL, on clr_n low, asynchronously force state IDLE, prescaler 0, d3..d0 = 0, running = 0, done = 0, expired = 0.
REQ-030 SHALL abort any in-progress countdown on reset, with no done pulse.
REQ-031 SHALL resume normal operation on the first rising edge after clr_n deasserts.

Verification (DIVISOR=4)
REQ-032 SHALL cover: load 00.03, go → running=1 next cycle; value 00.02/00.01/00.00 at 4-cycle intervals; done one cycle; expired=1, running=0.
REQ-033 SHALL cover: load 01.00, go, one tick → 00.59; load 10.00, one tick → 09.59.
REQ-034 SHALL cover: load 00.05, go, stop after 6 cycles (prescaler 1) → value 00.04 held.
REQ-035 SHALL cover: after REQ-034, go → next decrement exactly 3 cycles later (prescaler resumes).
REQ-036 SHALL cover: load d1_in=7, d0_in=12 → value 00.59; load 00.00, go → stays IDLE, running=0, no done.
REQ-037 SHALL cover: stop and tick in the same cycle at 00.01 → 00.00 with DONE and done pulse.
REQ-038 SHALL cover: clr_n pulse mid-RUN, asynchronous to clk → all outputs 0 immediately, state IDLE.
